noc_traffic_gen: RTL and testbench

- Synthesizable, parametrised per-port flit injector that drives one router input port with head/body/tail packets.
- Payload comes from an LFSR; destination, length, inter-packet gap (sets link utilisation), VC and packet count are configurable.
- It obeys the router's per-VC ready handshake.
- Instantiated once per router port in mesh and energy benches, it replaces task-driven stimulus and supports sustained, back-pressured traffic.

---
 rtl/noc_tg_pkg.sv | 29 ++
 rtl/noc_tg_lfsr.sv | 41 ++++
 rtl/noc_traffic_gen.sv | 177 +++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: shared definitions for the NoC traffic generator.
//   - flit type codes carried in the top TYPE_W bits of each flit
//   - generator FSM state enum
//   - 32-bit Fibonacci LFSR tap mask and single-step helper
package noc_tg_pkg;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;
    localparam logic [1:0] TYPE_DATA = 2'b11;

    // Taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_BODY = 3'd2,
        ST_TAIL = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } tg_state_e;

    // One shift-left step; the XOR of the tapped bits enters at bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/noc_tg_lfsr.sv
// noc_tg_lfsr: payload source for the traffic generator.
//   clk_i      clock
//   rst_i      synchronous active-high reset, reloads the seed
//   adv_i      advance strobe; loads the state reached after STEPS steps
//   payload_o  STEPS successive 32-bit steps, first step in the top word
module noc_tg_lfsr
    import noc_tg_pkg::*;
#(
    parameter int          STEPS = 2,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    output logic [STEPS*32-1:0]   payload_o
);

    // An all-zero state would lock the LFSR up.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d   = state_q;
        payload_o = '0;
        for (int i = 0; i < STEPS; i++) begin
            state_d = lfsr_step(state_d);
            payload_o[(STEPS - i) * 32 - 1 -: 32] = state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED_EFF;
        end else if (adv_i) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: per-port flit injector producing head/body/tail packets.
//   clk, rst_          clock, synchronous active-high reset
//   cfg_*              run enable, destination, body length, gap, VC, packet count
//   odata/ovalid/ovch  flit {type, payload}, valid and VC towards the router
//   ordy               router ready per VC; only ordy[ovch] matters
//   busy/done          packet or gap in progress / requested packet count sent
//   pkt_cnt, flit_cnt, stall_cnt  wrapping activity counters
//
// state | meaning
// IDLE  | waiting for cfg_en, config latched on exit
// HEAD  | head flit {SRC_ID, dst} offered
// BODY  | body flits offered, body_cnt_q remaining
// TAIL  | tail flit offered
// GAP   | idle for gap cycles after a tail
// DONE  | cfg_npkt packets sent, waits for cfg_en low
module noc_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int          DATA_W    = 64,
    parameter int          TYPE_W    = 2,
    parameter int          NUM_VC    = 4,
    parameter int          VCH_W     = 2,
    parameter int          LEN_W     = 8,
    parameter int          GAP_W     = 8,
    parameter logic [31:0] SRC_ID    = 32'h0,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       cfg_en,
    input  logic [31:0]                cfg_dst,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic [GAP_W-1:0]           cfg_gap,
    input  logic [VCH_W-1:0]           cfg_vc,
    input  logic [15:0]                cfg_npkt,
    output logic [TYPE_W+DATA_W-1:0]   odata,
    output logic                       ovalid,
    output logic [VCH_W-1:0]           ovch,
    input  logic [NUM_VC-1:0]          ordy,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                pkt_cnt,
    output logic [31:0]                flit_cnt,
    output logic [31:0]                stall_cnt
);

    localparam int STEPS = DATA_W / 32;

    tg_state_e          state_q, state_d;
    logic [31:0]        dst_q;
    logic [LEN_W-1:0]   body_cnt_q;
    logic [GAP_W-1:0]   gap_q, gap_cnt_q;
    logic [VCH_W-1:0]   vc_q;
    logic [15:0]        pkt_cnt_q;
    logic [31:0]        flit_cnt_q, stall_cnt_q;

    logic               accept;
    logic               latch;
    logic               lfsr_adv;
    logic [DATA_W-1:0]  payload;
    logic [DATA_W-1:0]  head_payload;

    assign accept   = ovalid && ordy[ovch];
    // Config is sampled on every entry into HEAD, never while a packet runs.
    assign latch    = (state_d == ST_HEAD) && (state_q != ST_HEAD);
    assign lfsr_adv = accept && ((state_q == ST_BODY) || (state_q == ST_TAIL));

    noc_tg_lfsr #(
        .STEPS (STEPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk_i     (clk),
        .rst_i     (rst_),
        .adv_i     (lfsr_adv),
        .payload_o (payload)
    );

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= ST_IDLE;
            dst_q       <= '0;
            body_cnt_q  <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            vc_q        <= '0;
            pkt_cnt_q   <= '0;
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                dst_q      <= cfg_dst;
                body_cnt_q <= cfg_len;
                gap_q      <= cfg_gap;
                vc_q       <= cfg_vc;
            end else if (state_q == ST_BODY && accept) begin
                body_cnt_q <= body_cnt_q - LEN_W'(1);
            end
            if (state_q == ST_TAIL && accept) begin
                gap_cnt_q <= gap_q;
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
            if (accept) begin
                flit_cnt_q <= flit_cnt_q + 32'd1;
            end
            if (ovalid && !ordy[ovch]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_en) state_d = ST_HEAD;
            ST_HEAD: if (accept) state_d = (body_cnt_q == '0) ? ST_TAIL : ST_BODY;
            ST_BODY: if (accept && body_cnt_q == LEN_W'(1)) state_d = ST_TAIL;
            ST_TAIL: begin
                if (accept) begin
                    if (cfg_npkt != 16'd0 && (pkt_cnt_q + 16'd1) == cfg_npkt)
                        state_d = ST_DONE;
                    else if (gap_q != '0)
                        state_d = ST_GAP;
                    else if (cfg_en)
                        state_d = ST_HEAD;
                    else
                        state_d = ST_IDLE;
                end
            end
            // gap_cnt_q == 1 marks the last of the gap idle cycles.
            ST_GAP:  if (gap_cnt_q == GAP_W'(1)) state_d = cfg_en ? ST_HEAD : ST_IDLE;
            ST_DONE: if (!cfg_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head_payload                     = '0;
        head_payload[DATA_W-1 -: 32]     = SRC_ID;
        head_payload[31:0]               = dst_q;
        odata  = {TYPE_W'(TYPE_NONE), {DATA_W{1'b0}}};
        ovalid = 1'b0;
        ovch   = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_HEAD: begin
                odata  = {TYPE_W'(TYPE_HEAD), head_payload};
                ovalid = 1'b1;
                ovch   = vc_q;
                busy   = 1'b1;
            end
            ST_BODY: begin
                odata  = {TYPE_W'(TYPE_DATA), payload};
                ovalid = 1'b1;
                ovch   = vc_q;
                busy   = 1'b1;
            end
            ST_TAIL: begin
                odata  = {TYPE_W'(TYPE_TAIL), payload};
                ovalid = 1'b1;
                ovch   = vc_q;
                busy   = 1'b1;
            end
            ST_GAP:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign flit_cnt  = flit_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Bench for noc_traffic_gen: directed scenarios plus randomized back-pressure,
// with accepted flits compared against a packet-level reference stream.
module tb_noc_traffic_gen;

    typedef logic [67:0] flit_t;   // {vc, type, payload}

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_dst = '0;
    logic [7:0]  cfg_len = '0;
    logic [7:0]  cfg_gap = '0;
    logic [1:0]  cfg_vc = '0;
    logic [15:0] cfg_npkt = '0;
    logic [65:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;
    logic [3:0]  ordy = 4'hf;
    logic        busy, done;
    logic [15:0] pkt_cnt;
    logic [31:0] flit_cnt, stall_cnt;

    int checks = 0;
    int failures = 0;

    flit_t       exp_q[$];
    flit_t       got_q[$];
    int          rd_idx = 0;
    int          m_stall = 0;
    int          stall_base = 0;
    logic [31:0] m_lfsr = 32'h1;

    noc_traffic_gen dut (
        .clk       (clk),
        .rst_      (rst_),
        .cfg_en    (cfg_en),
        .cfg_dst   (cfg_dst),
        .cfg_len   (cfg_len),
        .cfg_gap   (cfg_gap),
        .cfg_vc    (cfg_vc),
        .cfg_npkt  (cfg_npkt),
        .odata     (odata),
        .ovalid    (ovalid),
        .ovch      (ovch),
        .ordy      (ordy),
        .busy      (busy),
        .done      (done),
        .pkt_cnt   (pkt_cnt),
        .flit_cnt  (flit_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Record what the router would take, and stalled cycles, midway between edges.
    always @(negedge clk) begin
        if (!rst_) begin
            if (ovalid && ordy[ovch]) got_q.push_back({ovch, odata});
            if (ovalid && !ordy[ovch]) m_stall++;
        end
    end

    // Reference LFSR rule: shift left, b31^b21^b1^b0 into bit 0.
    function automatic logic [31:0] m_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic gen_payload(output logic [63:0] p);
        logic [31:0] a, b;
        a = m_step(m_lfsr);
        b = m_step(a);
        m_lfsr = b;
        p = {a, b};
    endtask

    task automatic push_pkt(input logic [31:0] dst, input int len, input logic [1:0] vc);
        logic [63:0] p;
        exp_q.push_back({vc, 2'b01, 32'h0, dst});
        for (int i = 0; i < len; i++) begin
            gen_payload(p);
            exp_q.push_back({vc, 2'b11, p});
        end
        gen_payload(p);
        exp_q.push_back({vc, 2'b10, p});
    endtask

    function automatic int stream_errors();
        int n = 0;
        int got_n = got_q.size() - rd_idx;
        if (got_n != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size() && i < got_n; i++)
            if (got_q[rd_idx + i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst_ = 1'b1;
        cfg_en = 1'b0;
        ordy = 4'hf;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        rd_idx = got_q.size();
        stall_base = m_stall;
        m_lfsr = 32'h1;
        rst_ = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] dst, input int len, input int gap,
                           input logic [1:0] vc, input int npkt);
        cfg_dst  = dst;
        cfg_len  = 8'(len);
        cfg_gap  = 8'(gap);
        cfg_vc   = vc;
        cfg_npkt = 16'(npkt);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ovalid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%0b exp=0", ovalid); end
        checks++; if (odata !== 66'h0) begin failures++; $display("FAIL reset_odata got=%h exp=0", odata); end
        checks++; if (ovch !== 2'd0) begin failures++; $display("FAIL reset_ovch got=%0d exp=0", ovch); end
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
        checks++; if ({pkt_cnt, flit_cnt, stall_cnt} !== 80'h0) begin failures++;
            $display("FAIL reset_counters got pkt=%0d flit=%0d stall=%0d exp=0", pkt_cnt, flit_cnt, stall_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        set_cfg(32'd9, 1, 0, 2'd2, 1);
        push_pkt(32'd9, 1, 2'd2);
        cfg_en = 1'b1;
        @(posedge clk); #1;
        checks++; if (odata !== {2'b01, 32'h0, 32'h9} || ovalid !== 1'b1 || ovch !== 2'd2) begin failures++;
            $display("FAIL single_head got=%h v=%0b vc=%0d exp=%h v=1 vc=2", odata, ovalid, ovch, {2'b01, 32'h0, 32'h9}); end
        @(posedge clk); #1;
        checks++; if (odata !== {2'b11, 32'h3, 32'h6} || ovch !== 2'd2) begin failures++;
            $display("FAIL single_data got=%h vc=%0d exp=%h vc=2", odata, ovch, {2'b11, 32'h3, 32'h6}); end
        @(posedge clk); #1;
        checks++; if (odata !== {2'b10, 32'hd, 32'h1b} || ovch !== 2'd2) begin failures++;
            $display("FAIL single_tail got=%h vc=%0d exp=%h vc=2", odata, ovch, {2'b10, 32'hd, 32'h1b}); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || ovalid !== 1'b0 || pkt_cnt !== 16'd1 || flit_cnt !== 32'd3) begin failures++;
            $display("FAIL single_done got done=%0b v=%0b pkt=%0d flit=%0d exp done=1 v=0 pkt=1 flit=3", done, ovalid, pkt_cnt, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL single_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_leave_done got=%0b exp=0", done); end
    endtask

    task automatic test_periodic();
        int bad_v = 0, bad_b = 0;
        logic [31:0] dst = $urandom;
        logic [1:0]  vc = 2'($urandom);
        do_reset();
        set_cfg(dst, 4, 7, vc, 10);
        for (int p = 0; p < 10; p++) push_pkt(dst, 4, vc);
        cfg_en = 1'b1;
        for (int k = 0; k < 130; k++) begin
            @(posedge clk); #1;
            if (ovalid !== ((k < 123) && (k % 13 < 6))) bad_v++;
            if (busy !== (k < 123)) bad_b++;
        end
        checks++; if (bad_v !== 0) begin failures++; $display("FAIL periodic_valid_pattern got_bad_cycles=%0d exp=0", bad_v); end
        checks++; if (bad_b !== 0) begin failures++; $display("FAIL periodic_busy_pattern got_bad_cycles=%0d exp=0", bad_b); end
        checks++; if (done !== 1'b1 || pkt_cnt !== 16'd10 || flit_cnt !== 32'd60) begin failures++;
            $display("FAIL periodic_end got done=%0b pkt=%0d flit=%0d exp done=1 pkt=10 flit=60", done, pkt_cnt, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL periodic_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
    endtask

    task automatic test_stall();
        logic [65:0] snap_d;
        logic [1:0]  vc = 2'($urandom);
        int bad = 0;
        do_reset();
        set_cfg(32'h1234, 6, 0, vc, 1);
        push_pkt(32'h1234, 6, vc);
        cfg_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        snap_d = odata;
        ordy = ~(4'b1 << vc);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (odata !== snap_d || ovalid !== 1'b1 || ovch !== vc) bad++;
            ordy = (i == 2) ? 4'hf : (4'($urandom) & ~(4'b1 << vc));
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold got_unstable_cycles=%0d exp=0", bad); end
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", stall_cnt); end
        for (int c = 0; c < 50 && done !== 1'b1; c++) begin @(posedge clk); #1; end
        checks++; if (done !== 1'b1 || flit_cnt !== 32'd8) begin failures++;
            $display("FAIL stall_end got done=%0b flit=%0d exp done=1 flit=8", done, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL stall_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
    endtask

    task automatic test_len0();
        logic [1:0] types [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] dst = $urandom;
        int bad = 0;
        do_reset();
        set_cfg(dst, 0, 0, 2'd3, 2);
        push_pkt(dst, 0, 2'd3);
        push_pkt(dst, 0, 2'd3);
        cfg_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ovalid !== 1'b1 || odata[65:64] !== types[k]) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL len0_head_tail got_bad_cycles=%0d exp=0", bad); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pkt_cnt !== 16'd2) begin failures++;
            $display("FAIL len0_done got done=%0b pkt=%0d exp done=1 pkt=2", done, pkt_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL len0_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        set_cfg(32'h77, 2, 0, 2'd1, 3);
        for (int p = 0; p < 3; p++) push_pkt(32'h77, 2, 2'd1);
        cfg_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ovalid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_full_rate got_idle_cycles=%0d exp=0", bad); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || flit_cnt !== 32'd12) begin failures++;
            $display("FAIL b2b_done got done=%0b flit=%0d exp done=1 flit=12", done, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL b2b_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cfg(32'h55, 5, 0, 2'd0, 0);
        cfg_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst_ = 1'b1;
        @(posedge clk); #1;
        checks++; if (ovalid !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL midrst_idle got v=%0b busy=%0b exp v=0 busy=0", ovalid, busy); end
        checks++; if ({pkt_cnt, flit_cnt, stall_cnt} !== 80'h0) begin failures++;
            $display("FAIL midrst_counters got pkt=%0d flit=%0d stall=%0d exp=0", pkt_cnt, flit_cnt, stall_cnt); end
        exp_q.delete();
        rd_idx = got_q.size();
        m_lfsr = 32'h1;
        set_cfg(32'h55, 5, 0, 2'd0, 1);
        push_pkt(32'h55, 5, 2'd0);
        rst_ = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (odata !== {2'b11, 32'h3, 32'h6}) begin failures++;
            $display("FAIL midrst_reseed got=%h exp=%h", odata, {2'b11, 32'h3, 32'h6}); end
        for (int c = 0; c < 50 && done !== 1'b1; c++) begin @(posedge clk); #1; end
        checks++; if (done !== 1'b1 || flit_cnt !== 32'd7) begin failures++;
            $display("FAIL midrst_end got done=%0b flit=%0d exp done=1 flit=7", done, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL midrst_stream got_errors=%0d exp=0", stream_errors()); end
        cfg_en = 1'b0;
    endtask

    task automatic test_en_drop();
        do_reset();
        set_cfg(32'h99, 4, 0, 2'd2, 0);
        push_pkt(32'h99, 4, 2'd2);
        cfg_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        cfg_en = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (ovalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL endrop_idle got v=%0b busy=%0b done=%0b exp 0 0 0", ovalid, busy, done); end
        checks++; if (pkt_cnt !== 16'd1 || flit_cnt !== 32'd6) begin failures++;
            $display("FAIL endrop_counts got pkt=%0d flit=%0d exp pkt=1 flit=6", pkt_cnt, flit_cnt); end
        checks++; if (stream_errors() !== 0) begin failures++; $display("FAIL endrop_stream got_errors=%0d exp=0", stream_errors()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [31:0] dst = $urandom;
            logic [1:0]  vc = 2'($urandom);
            int len  = $urandom_range(0, 5);
            int gap  = $urandom_range(0, 3);
            int npkt = $urandom_range(1, 4);
            do_reset();
            set_cfg(dst, len, gap, vc, npkt);
            for (int p = 0; p < npkt; p++) push_pkt(dst, len, vc);
            cfg_en = 1'b1;
            for (int c = 0; c < 600 && done !== 1'b1; c++) begin
                @(posedge clk); #1;
                ordy = 4'($urandom);
                ordy[vc] = ($urandom_range(0, 3) != 0);
            end
            ordy = 4'hf;
            checks++; if (done !== 1'b1 || pkt_cnt !== 16'(npkt)) begin failures++;
                $display("FAIL rand%0d_done got done=%0b pkt=%0d exp done=1 pkt=%0d", it, done, pkt_cnt, npkt); end
            checks++; if (flit_cnt !== 32'(npkt * (len + 2))) begin failures++;
                $display("FAIL rand%0d_flits got=%0d exp=%0d", it, flit_cnt, npkt * (len + 2)); end
            checks++; if (stall_cnt !== 32'(m_stall - stall_base)) begin failures++;
                $display("FAIL rand%0d_stalls got=%0d exp=%0d", it, stall_cnt, m_stall - stall_base); end
            checks++; if (stream_errors() !== 0) begin failures++;
                $display("FAIL rand%0d_stream got_errors=%0d exp=0", it, stream_errors()); end
            cfg_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_periodic();
        test_stall();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_en_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
